// File: rtl/tx_rr_scheduler.sv
// Round-robin arbiter sharing one serial transmitter between NREQ byte producers.
// Accepts one byte, pulses start, waits for done, then holds off for a programmable gap.
module tx_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned GAPW = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*DW-1:0]      req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ-1:0]         req_mask_i,
    input  logic [GAPW-1:0]         gap_i,
    output logic                    tx_start_o,
    output logic [DW-1:0]           tx_data_o,
    input  logic                    tx_done_i,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    busy_o
);

    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [GAPW-1:0] gap_q, gap_d;

    logic [NREQ-1:0] eligible;
    logic            win_any;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            found;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IW'(s % NREQ);
    endfunction

    assign eligible = req_valid_i & req_mask_i;
    assign win_any  = |eligible;

    // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_idx(rr_ptr_q, i);
            if (!found && eligible[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == StIdle && win_any) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        gap_d    = gap_q;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    data_d  = req_data_i[win_idx*DW +: DW];
                    grant_d = win_idx;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done_i) begin
                    rr_ptr_d = wrap_idx(grant_q, 1);
                    if (gap_i == '0) begin
                        state_d = StIdle;
                    end else begin
                        gap_d   = gap_i;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - GAPW'(1);
                if (gap_q == GAPW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            gap_q    <= gap_d;
        end
    end

    assign tx_start_o = (state_q == StStart);
    assign busy_o     = (state_q != StIdle);
    assign tx_data_o  = data_q;
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_tx_rr_scheduler.sv
// Self-checking bench for tx_rr_scheduler: per-cycle frame-level model plus directed scenarios.
module tb_tx_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  req_mask;
    logic [7:0]  gap;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;

    int checks;
    int failures;

    // Model: a frame is either in flight (age = cycles since accept) or the link
    // is cooling down for m_gap cycles; otherwise it is free to accept.
    bit          m_known;
    bit          m_in_flight;
    int          m_age;
    int          m_gap;
    int          m_ptr;
    int          m_id;
    logic [7:0]  m_data;

    tx_rr_scheduler #(
        .NREQ(4),
        .DW  (8),
        .GAPW(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .req_mask_i (req_mask),
        .gap_i      (gap),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_done_i  (tx_done),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int off = 0; off < 4; off++) begin
            int k = (m_ptr + off) % 4;
            if (req_valid[k] && req_mask[k]) return k;
        end
        return -1;
    endfunction

    initial begin
        int w;
        logic [3:0] exp_ready;
        m_known = 0;
        m_in_flight = 0;
        m_age = 0;
        m_gap = 0;
        m_ptr = 0;
        m_id = 0;
        m_data = '0;
        forever begin
            @(negedge clk);
            w = model_winner();
            if (m_known) begin
                exp_ready = (!m_in_flight && m_gap == 0 && w >= 0) ? 4'(1 << w) : 4'b0;
                check("model_ready", 32'(req_ready), 32'(exp_ready));
                check("model_start", 32'(tx_start), 32'(m_in_flight && m_age == 1));
                check("model_busy", 32'(busy), 32'(m_in_flight || m_gap > 0));
                check("model_data", 32'(tx_data), 32'(m_data));
                check("model_grant", 32'(grant_id), 32'(m_id));
            end
            // Advance the model across the coming rising edge.
            if (rst) begin
                m_known = 1;
                m_in_flight = 0;
                m_age = 0;
                m_gap = 0;
                m_ptr = 0;
                m_id = 0;
                m_data = '0;
            end else if (m_known) begin
                if (m_in_flight) begin
                    if (m_age >= 2 && tx_done) begin
                        m_in_flight = 0;
                        m_ptr = (m_id + 1) % 4;
                        m_gap = int'(gap);
                    end else begin
                        m_age++;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (w >= 0) begin
                    m_in_flight = 1;
                    m_age = 1;
                    m_id = w;
                    m_data = req_data[w*8 +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = 4'b0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for a grant, check it, then complete the frame with a done pulse.
    task automatic do_frame(input string tag, input logic [3:0] exp_ready,
                            input logic [7:0] exp_data, input logic [1:0] exp_id,
                            input int done_after, input bit clear_valid);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) break;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        tick();
        if (clear_valid) req_valid = 4'b0;
        @(negedge clk);
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
        check({tag, "_grant"}, 32'(grant_id), 32'(exp_id));
        repeat (done_after) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = 4'b0;
        req_mask = 4'hF;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        gap = 8'd0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single requester
        tick();
        req_data = {8'h13, 8'h12, 8'h11, 8'h5A};
        req_valid = 4'b0001;
        do_frame("single", 4'b0001, 8'h5A, 2'd0, 35, 1'b1);
        @(negedge clk);
        check("single_busy_fall", 32'(busy), 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("single_ptr_next", 32'(req_ready), 32'(4'b0010));
        tick();
        reset_dut();

        // Round robin over all four
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        do_frame("rr0", 4'b0001, 8'h10, 2'd0, 35, 1'b0);
        do_frame("rr1", 4'b0010, 8'h11, 2'd1, 35, 1'b0);
        do_frame("rr2", 4'b0100, 8'h12, 2'd2, 35, 1'b0);
        do_frame("rr3", 4'b1000, 8'h13, 2'd3, 35, 1'b0);
        do_frame("rr4", 4'b0001, 8'h10, 2'd0, 35, 1'b0);
        reset_dut();

        // Masked requesters never win
        req_mask = 4'b1010;
        req_valid = 4'hF;
        do_frame("mask0", 4'b0010, 8'h11, 2'd1, 10, 1'b0);
        do_frame("mask1", 4'b1000, 8'h13, 2'd3, 10, 1'b0);
        do_frame("mask2", 4'b0010, 8'h11, 2'd1, 10, 1'b0);
        do_frame("mask3", 4'b1000, 8'h13, 2'd3, 10, 1'b0);
        reset_dut();
        req_mask = 4'hF;

        // Inter-frame gap of 5
        gap = 8'd5;
        req_valid = 4'b0011;
        do_frame("gap", 4'b0001, 8'h10, 2'd0, 10, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_ready", 32'(req_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        check("gap_next_ready", 32'(req_ready), 32'(4'b0010));
        gap = 8'd0;
        tick();
        reset_dut();

        // Spurious done in IDLE and START
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        check("spur_idle_busy", 32'(busy), 32'd0);
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        check("spur_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = 4'b0;
        tx_done = 1'b1;
        @(negedge clk);
        check("spur_start", 32'(tx_start), 32'd1);
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        check("spur_wait_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        @(negedge clk);
        check("spur_still_busy", 32'(busy), 32'd1);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        check("spur_done_busy", 32'(busy), 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("spur_ptr_next", 32'(req_ready), 32'(4'b1000));
        tick();
        reset_dut();

        // Reset in the middle of a frame
        req_valid = 4'b0100;
        @(negedge clk);
        check("mid_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = 4'b0;
        repeat (3) tick();
        @(negedge clk);
        check("mid_grant", 32'(grant_id), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_start", 32'(tx_start), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        @(negedge clk);
        check("mid_late_done", 32'(busy), 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        check("mid_next_ready", 32'(req_ready), 32'(4'b0001));
        tick();
        @(negedge clk);
        check("mid_next_grant", 32'(grant_id), 32'd0);
        check("mid_next_start", 32'(tx_start), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_rr_scheduler.md
Name: tx_rr_scheduler

Overview:
- Round-robin scheduler that shares one serial transmitter (tx_serial with FSM) between NREQ byte producers.
- Accepts one byte at a time from the winning requester through a valid/ready handshake, then launches the transmitter with a single-cycle start pulse.
- Waits for the transmitter's done pulse, then enforces a programmable inter-frame gap before arbitrating again.
- Sits between the producer blocks and the transmitter; dvsr_i to the transmitter is not touched here.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- GAPW, 8, width of the gap counter and of gap_i.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester data valid.
- req_data_i  in  NREQ*DW  packed data; requester k occupies bits [k*DW +: DW].
- req_ready_o  out  NREQ  one-hot accept strobe.
- req_mask_i  in  NREQ  1 = requester k enabled; masked requesters are never granted.
- gap_i  in  GAPW  idle clocks inserted after each done pulse (0 = no gap).
- tx_start_o  out  1  single-cycle start pulse to the transmitter.
- tx_data_o  out  DW  byte presented to the transmitter; stable from start until done.
- tx_done_i  in  1  single-cycle frame-complete pulse from the transmitter.
- grant_id_o  out  $clog2(NREQ)  index of the requester whose byte is in flight.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, rr_ptr=0, tx_start_o=0, tx_data_o=0, grant_id_o=0, busy_o=0, gap counter=0.
  - Reset takes priority over every other event, including mid-frame.
  - A tx_done_i pulse that arrives after reset is ignored.
- Eligible set: E[k] = req_valid_i[k] & req_mask_i[k].
- Winner: the first k with E[k]=1, searched in order rr_ptr, rr_ptr+1, ... NREQ-1, 0, ... (modulo NREQ).
- req_ready_o is combinational: one-hot at the winner only while state=IDLE and E≠0; all zeros otherwise.
  - A transfer occurs on a cycle where req_valid_i[k] & req_ready_o[k] = 1.
- States:
  - IDLE:
    - If E≠0: latch the winner's data into tx_data_o and its index into grant_id_o, then go to START.
    - If E=0: stay in IDLE.
  - START:
    - tx_start_o=1 for exactly this one cycle, then go to WAIT.
    - tx_done_i is ignored in this state.
  - WAIT:
    - Hold tx_data_o and grant_id_o.
    - On tx_done_i=1: set rr_ptr=(grant_id_o+1) mod NREQ.
    - Next state is IDLE if gap_i=0. Otherwise load the gap counter with gap_i and go to GAP.
    - No timeout.
  - GAP:
    - Decrement the counter each cycle.
    - When the counter equals 1, go to IDLE.
    - gap_i is sampled only on entry to GAP.
    - tx_done_i is ignored in this state.
- Latency:
  - Accept cycle at edge N; tx_start_o high in cycle N+1.
  - Done pulse at edge D; with gap_i=G, the next accept is possible at edge D+1+G at the earliest.
- tx_done_i in IDLE is ignored.
- Mask and valid changes take effect in the same cycle (combinational arbitration).
  - A requester dropping valid while in IDLE simply loses arbitration; no byte is accepted.
- Only one byte is ever outstanding, and no requester is granted twice while another eligible requester is waiting.

Test Plan:
- Single requester: NREQ=4, gap_i=0, req_valid_i=0001, data 0x5A.
  - req_ready_o=0001 for 1 cycle, tx_start_o pulses the next cycle, tx_data_o=0x5A.
  - Drive tx_done_i 35 cycles later: busy_o falls 1 cycle after done, rr_ptr=1.
- Round robin: all four valid continuously, data 0x10+k, gap_i=0, done 35 cycles after each start.
  - Grant order 0,1,2,3,0; tx_data_o 0x10,0x11,0x12,0x13,0x10.
- Mask: req_valid_i=1111, req_mask_i=1010.
  - Grants alternate 1,3,1,3; req_ready_o[0] and req_ready_o[2] are never asserted.
- Gap: gap_i=5, two requesters valid.
  - Exactly 5 cycles in GAP with busy_o=1; second req_ready_o occurs 6 cycles after the done pulse.
- Spurious done: pulse tx_done_i in IDLE and in START.
  - No state change and no rr_ptr change; the frame still completes only on the done pulse in WAIT.
- Reset mid-frame: assert rst_i in WAIT with grant_id_o=2.
  - Next cycle: all outputs 0, state IDLE; a following done pulse is ignored; the next grant starts search at 0.
